// File: rtl/mux_display_pkg.sv
// mux_display_pkg: segment glyphs (active-low, a..g on [7:1], dp=1 off), digit anode selects, capture FSM states
package mux_display_pkg;
  localparam logic [7:0] SEG_0 = 8'h03;
  localparam logic [7:0] SEG_1 = 8'h9F;
  localparam logic [7:0] SEG_2 = 8'h25;
  localparam logic [7:0] SEG_3 = 8'h0D;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h49;
  localparam logic [7:0] SEG_6 = 8'h41;
  localparam logic [7:0] SEG_7 = 8'h1F;
  localparam logic [7:0] SEG_8 = 8'h01;
  localparam logic [7:0] SEG_9 = 8'h09;
  localparam logic [7:0] SEG_A = 8'h11;
  localparam logic [7:0] SEG_B = 8'hC1;
  localparam logic [7:0] SEG_C = 8'h63;
  localparam logic [7:0] SEG_D = 8'h85;
  localparam logic [7:0] SEG_E = 8'h61;
  localparam logic [7:0] SEG_F = 8'h71;
  localparam logic [7:0] SEG_S = SEG_5;
  localparam logic [7:0] SEG_I = SEG_1;
  localparam logic [7:0] SEG_Z = SEG_2;
  localparam logic [7:0] SEG_J = 8'h87;
  localparam logic [7:0] SEG_TAB [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                          SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
  localparam logic [7:0] AN_D0 = 8'hFE;
  localparam logic [7:0] AN_D1 = 8'hFD;
  localparam logic [7:0] AN_D2 = 8'hFB;
  localparam logic [7:0] AN_D3 = 8'hF7;
  typedef enum logic {WAIT, HOLD} state_t;
endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: active-low cathode pattern to {known, code}; ports cx (dp ignored), known, code
module seg7_to_hex
  import mux_display_pkg::*;
(
  input  logic [7:0] cx,
  output logic       known,
  output logic [3:0] code
);
  always_comb begin
    known = 1'b0;
    code = 4'h0;
    for (int i = 0; i < 16; i++)
      if ((cx | 8'h01) == SEG_TAB[i]) begin
        known = 1'b1;
        code = 4'(i);
      end
  end
endmodule

// File: rtl/mux_display_capture.sv
// mux_display_capture: recovers a 4-digit hex frame from a multiplexed active-low 7-segment bus
// ports: clk, reset (async high), an_in/cx_in display bus; digits, digit_known, frame_valid pulse, stale, err_sticky
module mux_display_capture
  import mux_display_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 250_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  an_in,
  input  logic [7:0]  cx_in,
  output logic [15:0] digits,
  output logic [3:0]  digit_known,
  output logic        frame_valid,
  output logic        stale,
  output logic        err_sticky
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] SET = 8'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
  logic [15:0] sync1, sync2, prev, shd;
  logic [7:0] an_s, cx_s, stab_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0] shd_k, seen, sel, code;
  logic changed, legal, illegal, evt, cap, expire, known, full;
  state_t st;
  assign {an_s, cx_s} = sync2;
  assign sel = ~an_s[3:0];
  assign changed = sync2 != prev;
  assign legal = an_s inside {AN_D0, AN_D1, AN_D2, AN_D3};
  assign illegal = !legal && an_s != 8'hFF;
  // fires once per dwell, on the cycle the counter reaches SETTLE_CYCLES
  assign evt = st == WAIT && stab_cnt == SET - 8'd1 && !changed;
  assign cap = evt && legal;
  assign expire = !cap && to_cnt == TO_LAST;
  assign full = seen == 4'hF;
  seg7_to_hex u_dec (.cx(cx_s), .known(known), .code(code));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1 <= 16'hFFFF;
      sync2 <= 16'hFFFF;
      prev <= 16'hFFFF;
      stab_cnt <= '0;
      st <= WAIT;
      err_sticky <= 1'b0;
      to_cnt <= '0;
      shd <= '0;
      shd_k <= '0;
      seen <= '0;
      frame_valid <= 1'b0;
      digits <= '0;
      digit_known <= '0;
      stale <= 1'b1;
    end else begin
      sync1 <= {an_in, cx_in};
      sync2 <= sync1;
      prev <= sync2;
      stab_cnt <= changed ? '0 : stab_cnt == SET ? stab_cnt : stab_cnt + 8'd1;
      st <= evt ? HOLD : (st == HOLD && changed) ? WAIT : st;
      err_sticky <= err_sticky | (evt && illegal);
      to_cnt <= cap ? '0 : to_cnt == TO_MAX ? to_cnt : to_cnt + 1'b1;
      for (int i = 0; i < 4; i++)
        if (cap && sel[i]) begin
          shd[4*i+:4] <= code;
          shd_k[i] <= known;
        end
      seen <= (expire || full) ? '0 : seen | (cap ? sel : 4'h0);
      frame_valid <= full;
      if (full) begin
        digits <= shd;
        digit_known <= shd_k;
      end
      stale <= expire | (stale & !full);
    end
endmodule

// File: tb/tb_mux_display_capture.sv
// tb_mux_display_capture: directed frame vectors plus glitch, illegal-select, timeout and reset sequences
module tb_mux_display_capture;
  localparam int T = 200;
  localparam int DW = 40;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] an_in = 8'hFF;
  logic [7:0] cx_in = 8'hFF;
  logic [15:0] digits;
  logic [3:0] digit_known;
  logic frame_valid, stale, err_sticky;
  int tests = 0;
  int fails = 0;
  int fv_cnt = 0;
  int base;
  typedef struct packed {
    logic [31:0] cx;
    logic [15:0] dig;
    logic [3:0]  kn;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  mux_display_capture #(.SETTLE_CYCLES(16), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .an_in(an_in), .cx_in(cx_in),
    .digits(digits), .digit_known(digit_known), .frame_valid(frame_valid),
    .stale(stale), .err_sticky(err_sticky)
  );

  always @(negedge clk) if (frame_valid) fv_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic dwell(input logic [7:0] an, input logic [7:0] cx, input int n);
    an_in = an;
    cx_in = cx;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [31:0] cx);
    dwell(8'hF7, cx[31:24], DW);
    dwell(8'hFB, cx[23:16], DW);
    dwell(8'hFD, cx[15:8], DW);
    dwell(8'hFE, cx[7:0], DW);
  endtask

  initial begin
    vecs[0] = {32'h9F090909, 16'h1999, 4'hF};
    vecs[1] = {32'h87112525, 16'h0A22, 4'b0111};
    vecs[2] = {32'h63038561, 16'hC0DE, 4'hF};
    vecs[3] = {32'h4810C01E, 16'h5AB7, 4'hF};
    vecs[4] = {32'hFD99FF41, 16'h0406, 4'b0101};
    vecs[5] = {32'h0D710161, 16'h3F8E, 4'hF};
    repeat (3) @(negedge clk);
    check("rst digits", 32'(digits), 32'h0);
    check("rst known", 32'(digit_known), 32'h0);
    check("rst frame_valid", 32'(frame_valid), 32'h0);
    check("rst stale", 32'(stale), 32'h1);
    check("rst err", 32'(err_sticky), 32'h0);
    reset = 1'b0;
    for (int v = 0; v < 6; v++)
      for (int r = 0; r < 3; r++) begin
        base = fv_cnt;
        scan(vecs[v].cx);
        check($sformatf("vec%0d.r%0d frames", v, r), 32'(fv_cnt - base), 32'd1);
        check($sformatf("vec%0d.r%0d digits", v, r), 32'(digits), 32'(vecs[v].dig));
        check($sformatf("vec%0d.r%0d known", v, r), 32'(digit_known), 32'(vecs[v].kn));
        check($sformatf("vec%0d.r%0d stale", v, r), 32'(stale), 32'h0);
      end
    base = fv_cnt;
    dwell(8'hF7, 8'h9F, DW);
    dwell(8'hFB, 8'h09, 20);
    dwell(8'hF7, 8'h00, 10);
    dwell(8'hFB, 8'h09, 20);
    dwell(8'hFD, 8'h09, DW);
    dwell(8'hFE, 8'h09, DW);
    check("glitch frames", 32'(fv_cnt - base), 32'd1);
    check("glitch digits", 32'(digits), 32'h1999);
    dwell(8'hF3, 8'h01, 10);
    check("short illegal err", 32'(err_sticky), 32'h0);
    dwell(8'hFF, 8'hFF, 20);
    base = fv_cnt;
    dwell(8'hF3, 8'h01, 20);
    check("illegal err", 32'(err_sticky), 32'h1);
    dwell(8'hFD, 8'h09, DW);
    dwell(8'hFE, 8'h09, DW);
    check("illegal no slot", 32'(fv_cnt - base), 32'd0);
    dwell(8'hF7, 8'h9F, DW);
    dwell(8'hFB, 8'h09, DW);
    check("after illegal frames", 32'(fv_cnt - base), 32'd1);
    check("after illegal digits", 32'(digits), 32'h1999);
    check("err sticky", 32'(err_sticky), 32'h1);
    base = fv_cnt;
    dwell(8'hF7, 8'h63, DW);
    dwell(8'hFB, 8'h03, DW);
    dwell(8'hFD, 8'h85, DW);
    dwell(8'hFE, 8'h61, DW);
    dwell(8'hFF, 8'hFF, 18 + T - DW);
    check("timeout frames", 32'(fv_cnt - base), 32'd1);
    check("stale one before", 32'(stale), 32'h0);
    @(negedge clk);
    check("stale at timeout", 32'(stale), 32'h1);
    check("stale digits held", 32'(digits), 32'hC0DE);
    check("stale known held", 32'(digit_known), 32'hF);
    base = fv_cnt;
    dwell(8'hF7, 8'h9F, DW);
    check("stale until frame", 32'(stale), 32'h1);
    dwell(8'hFB, 8'h09, DW);
    dwell(8'hFD, 8'h09, DW);
    dwell(8'hFE, 8'h09, DW);
    check("resume frames", 32'(fv_cnt - base), 32'd1);
    check("resume stale", 32'(stale), 32'h0);
    check("resume digits", 32'(digits), 32'h1999);
    dwell(8'hF7, 8'h01, DW);
    dwell(8'hFB, 8'h01, DW);
    reset = 1'b1;
    #1;
    check("midrst digits", 32'(digits), 32'h0);
    check("midrst known", 32'(digit_known), 32'h0);
    check("midrst frame_valid", 32'(frame_valid), 32'h0);
    check("midrst stale", 32'(stale), 32'h1);
    check("midrst err", 32'(err_sticky), 32'h0);
    an_in = 8'hFF;
    cx_in = 8'hFF;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base = fv_cnt;
    dwell(8'hFD, 8'h85, DW);
    dwell(8'hFE, 8'h61, DW);
    dwell(8'hF7, 8'h63, DW);
    check("partial discarded", 32'(fv_cnt - base), 32'd0);
    check("partial stale", 32'(stale), 32'h1);
    dwell(8'hFB, 8'h03, DW);
    check("post rst frames", 32'(fv_cnt - base), 32'd1);
    check("post rst digits", 32'(digits), 32'hC0DE);
    check("post rst known", 32'(digit_known), 32'hF);
    check("post rst stale", 32'(stale), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
